// File: rtl/light_package.sv
// Shared definitions for the loop-detector conditioning path.
//   SENSOR_CNT  : number of independent detector channels
//   deb_state_t : per-channel debounce state
package light_package;

  localparam int unsigned SENSOR_CNT = 5;

  typedef enum logic [1:0] {
    LO      = 2'd0,
    PEND_HI = 2'd1,
    HI      = 2'd2,
    PEND_LO = 2'd3
  } deb_state_t;

endpackage

// File: rtl/sensor_channel.sv
// One detector channel: 2-flop synchronizer, debounce FSM, stuck detector.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-low reset
//   raw       : asynchronous raw detector level
//   fault_clr : one-cycle pulse clearing the stuck flag and counter
//   sensor    : debounced level (registered)
//   fault     : sticky stuck flag (registered)
module sensor_channel
  import light_package::*;
#(
  parameter int unsigned DEB_CYCLES   = 3,
  parameter int unsigned STUCK_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic fault_clr,
  output logic sensor,
  output logic fault
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);

  logic            sync1;
  logic            sync2;
  deb_state_t      state;
  deb_state_t      state_nxt;
  logic [DW-1:0]   deb_cnt;
  logic [DW-1:0]   deb_cnt_nxt;
  logic            sensor_nxt;
  logic [SW-1:0]   stuck_cnt;
  logic [SW-1:0]   stuck_cnt_nxt;
  logic            fault_nxt;

  // Metastability synchronizer
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= LO;
      deb_cnt <= '0;
      sensor  <= 1'b0;
    end else begin
      state   <= state_nxt;
      deb_cnt <= deb_cnt_nxt;
      sensor  <= sensor_nxt;
    end
  end

  // Debounce next-state: a level must be seen DEB_CYCLES times in a row
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    case (state)
      LO: begin
        if (sync2) begin
          if (DEB_CYCLES <= 1) begin
            state_nxt   = HI;
            deb_cnt_nxt = '0;
          end else begin
            state_nxt   = PEND_HI;
            deb_cnt_nxt = DW'(1);
          end
        end
      end
      PEND_HI: begin
        if (!sync2) begin
          state_nxt   = LO;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
          state_nxt   = HI;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + DW'(1);
        end
      end
      HI: begin
        if (!sync2) begin
          if (DEB_CYCLES <= 1) begin
            state_nxt   = LO;
            deb_cnt_nxt = '0;
          end else begin
            state_nxt   = PEND_LO;
            deb_cnt_nxt = DW'(1);
          end
        end
      end
      PEND_LO: begin
        if (sync2) begin
          state_nxt   = HI;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
          state_nxt   = LO;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + DW'(1);
        end
      end
      default: begin
        state_nxt   = LO;
        deb_cnt_nxt = '0;
      end
    endcase
    sensor_nxt = (state_nxt == HI) || (state_nxt == PEND_LO);
  end

  // Stuck detector register
  always_ff @(posedge clk) begin
    if (!reset) begin
      stuck_cnt <= '0;
      fault     <= 1'b0;
    end else begin
      stuck_cnt <= stuck_cnt_nxt;
      fault     <= fault_nxt;
    end
  end

  // Count consecutive asserted cycles; clear has priority over a new flag
  always_comb begin
    stuck_cnt_nxt = stuck_cnt;
    fault_nxt     = fault;
    if (fault_clr) begin
      stuck_cnt_nxt = '0;
      fault_nxt     = 1'b0;
    end else if (!sensor) begin
      stuck_cnt_nxt = '0;
    end else if (stuck_cnt != SW'(STUCK_CYCLES)) begin
      stuck_cnt_nxt = stuck_cnt + SW'(1);
      if (stuck_cnt_nxt == SW'(STUCK_CYCLES)) begin
        fault_nxt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions five loop-detector inputs for the traffic light controller.
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-low reset
//   *_raw                 : asynchronous raw detector levels
//   fault_clr             : one-cycle pulse clearing all stuck flags
//   *_sensor              : debounced levels (registered)
//   fault[4:0]            : stuck flags {e_left, e_str, w_left, w_str, ns}
//   fault_any             : OR of fault (combinational from fault flops)
module sensor_conditioner
  import light_package::*;
#(
  parameter int unsigned DEB_CYCLES   = 3,
  parameter int unsigned STUCK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  e_left_raw,
  input  logic                  e_str_raw,
  input  logic                  w_left_raw,
  input  logic                  w_str_raw,
  input  logic                  ns_raw,
  input  logic                  fault_clr,
  output logic                  e_left_sensor,
  output logic                  e_str_sensor,
  output logic                  w_left_sensor,
  output logic                  w_str_sensor,
  output logic                  ns_sensor,
  output logic [SENSOR_CNT-1:0] fault,
  output logic                  fault_any
);

  logic [SENSOR_CNT-1:0] raw_vec;
  logic [SENSOR_CNT-1:0] sensor_vec;

  assign raw_vec = {e_left_raw, e_str_raw, w_left_raw, w_str_raw, ns_raw};

  // Independent channels, one per detector
  for (genvar i = 0; i < SENSOR_CNT; i++) begin : g_ch
    sensor_channel #(
      .DEB_CYCLES  (DEB_CYCLES),
      .STUCK_CYCLES(STUCK_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .raw      (raw_vec[i]),
      .fault_clr(fault_clr),
      .sensor   (sensor_vec[i]),
      .fault    (fault[i])
    );
  end

  assign {e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor} = sensor_vec;
  assign fault_any = |fault;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner (DEB_CYCLES=3, STUCK_CYCLES=64).
module tb_sensor_conditioner;

  localparam int DEB   = 3;
  localparam int STUCK = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [4:0] raw_v;
  logic       e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor;
  logic [4:0] fault;
  logic       fault_any;
  logic [4:0] sens;

  int checks = 0;
  int errors = 0;

  // Reference model: sync pipeline, window of last DEB samples, stuck run length
  bit p1 [5];
  bit p2 [5];
  bit win [5][DEB];
  bit mout [5];
  int mcnt [5];
  bit mflt [5];

  typedef struct {
    logic [4:0]  raw;
    int          steps;
    logic [4:0]  exp_sens;
  } vec_t;
  vec_t tbl [8];

  int hold [5];

  sensor_conditioner #(.DEB_CYCLES(DEB), .STUCK_CYCLES(STUCK)) dut (
    .clk          (clk),
    .reset        (rst),
    .e_left_raw   (raw_v[4]),
    .e_str_raw    (raw_v[3]),
    .w_left_raw   (raw_v[2]),
    .w_str_raw    (raw_v[1]),
    .ns_raw       (raw_v[0]),
    .fault_clr    (clr),
    .e_left_sensor(e_left_sensor),
    .e_str_sensor (e_str_sensor),
    .w_left_sensor(w_left_sensor),
    .w_str_sensor (w_str_sensor),
    .ns_sensor    (ns_sensor),
    .fault        (fault),
    .fault_any    (fault_any)
  );

  assign sens = {e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < 5; c++) begin
      if (!rst) begin
        p1[c] = 1'b0;
        p2[c] = 1'b0;
        for (int k = 0; k < DEB; k++) win[c][k] = 1'b0;
        mout[c] = 1'b0;
        mcnt[c] = 0;
        mflt[c] = 1'b0;
      end else begin
        bit s;
        bit all;
        bit nout;
        s     = p2[c];
        p2[c] = p1[c];
        p1[c] = raw_v[c];
        for (int k = DEB - 1; k > 0; k--) win[c][k] = win[c][k-1];
        win[c][0] = s;
        all = 1'b1;
        for (int k = 0; k < DEB; k++) if (win[c][k] != s) all = 1'b0;
        nout = (all && (s != mout[c])) ? s : mout[c];
        if (clr) begin
          mcnt[c] = 0;
          mflt[c] = 1'b0;
        end else if (mout[c]) begin
          if (mcnt[c] < STUCK) mcnt[c]++;
          if (mcnt[c] == STUCK) mflt[c] = 1'b1;
        end else begin
          mcnt[c] = 0;
        end
        mout[c] = nout;
      end
    end
  endtask

  // One clock edge: update model, then compare all outputs against it
  task automatic step();
    logic [10:0] exp;
    logic        any;
    @(posedge clk);
    model_update();
    #1;
    any = 1'b0;
    for (int c = 0; c < 5; c++) begin
      exp[c+6] = mout[c];
      exp[c+1] = mflt[c];
      any      = any | mflt[c];
    end
    exp[0] = any;
    chk("model", 32'({sens, fault, fault_any}), 32'(exp));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    steps(2);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    rst   = 1'b0;
    clr   = 1'b0;
    raw_v = '0;
    @(negedge clk);
    do_reset();
    chk("reset_sens", 32'(sens), 32'(0));
    chk("reset_fault", 32'({fault, fault_any}), 32'(0));

    // Table-driven level sequences from a clean reset
    tbl[0] = '{5'b10000, 4,  5'b00000};
    tbl[1] = '{5'b10000, 1,  5'b10000};
    tbl[2] = '{5'b01001, 5,  5'b01001};
    tbl[3] = '{5'b01001, 10, 5'b01001};
    tbl[4] = '{5'b11111, 2,  5'b01001};
    tbl[5] = '{5'b01001, 2,  5'b01001};
    tbl[6] = '{5'b01001, 5,  5'b01001};
    tbl[7] = '{5'b00000, 5,  5'b00000};
    for (int i = 0; i < 8; i++) begin
      raw_v = tbl[i].raw;
      steps(tbl[i].steps);
      chk($sformatf("tbl%0d_sens", i), 32'(sens), 32'(tbl[i].exp_sens));
      chk($sformatf("tbl%0d_fault", i), 32'(fault), 32'(0));
    end

    // All channels rise together, then fall together
    raw_v = 5'b11111;
    steps(4);
    chk("all_rise_early", 32'(sens), 32'(0));
    step();
    chk("all_rise", 32'(sens), 32'(5'b11111));
    raw_v = 5'b00000;
    steps(4);
    chk("all_fall_early", 32'(sens), 32'(5'b11111));
    step();
    chk("all_fall", 32'(sens), 32'(0));
    steps(4);

    // Stuck detection on w_str, clear, re-flag, clear-wins-over-set
    do_reset();
    raw_v = 5'b00010;
    steps(5);
    chk("wstr_rise", 32'(w_str_sensor), 32'(1));
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (fault[1] && n == 0) n = i;
      if (n != 0) break;
    end
    chk("stuck_latency", 32'(n), 32'(STUCK));
    chk("stuck_any", 32'(fault_any), 32'(1));
    chk("stuck_only_wstr", 32'(fault), 32'(5'b00010));
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_fault", 32'({fault, fault_any}), 32'(0));
    steps(STUCK - 1);
    chk("reflag_early", 32'(fault[1]), 32'(0));
    step();
    chk("reflag", 32'(fault[1]), 32'(1));
    chk("fault_no_effect", 32'(w_str_sensor), 32'(1));
    clr = 1'b1;
    step();
    clr = 1'b0;
    steps(STUCK - 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_wins", 32'(fault[1]), 32'(0));
    raw_v = '0;
    steps(8);

    // Reset during PEND_HI on e_str abandons the pending rise
    do_reset();
    raw_v = 5'b01000;
    steps(3);
    rst = 1'b0;
    step();
    chk("rst_pend_sens", 32'(e_str_sensor), 32'(0));
    rst = 1'b1;
    steps(4);
    chk("rst_rel_early", 32'(e_str_sensor), 32'(0));
    step();
    chk("rst_rel_rise", 32'(e_str_sensor), 32'(1));

    // Randomized run-length stimulus against the model
    raw_v = '0;
    do_reset();
    for (int c = 0; c < 5; c++) hold[c] = 1;
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < 5; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          raw_v[c] = ~raw_v[c];
          hold[c]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 100))
                                                 : int'($urandom_range(1, 6));
        end
      end
      clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 499) != 0);
      step();
    end
    clr = 1'b0;
    rst = 1'b1;
    steps(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 3: number of consecutive stable cycles required before a sensor output changes.
REQ-002 SHALL have parameter STUCK_CYCLES, default 64: number of consecutive asserted cycles after which a channel is flagged stuck.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have ports e_left_raw, e_str_raw, w_left_raw, w_str_raw, ns_raw, each input, 1 bit: asynchronous raw loop-detector levels.
REQ-006 SHALL have ports e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor, each output, 1 bit: conditioned levels that feed traffic_light_controller directly.
REQ-007 SHALL have port fault_clr, input, 1 bit: one-cycle pulse that clears all stuck flags.
REQ-008 SHALL have port fault, output, 5 bits: per-channel stuck flags; bit order is [4]=e_left, [3]=e_str, [2]=w_left, [1]=w_str, [0]=ns.
REQ-009 SHALL have port fault_any, output, 1 bit: OR of fault.

Function
REQ-010 Each channel SHALL pass its raw input through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-011 Each channel SHALL run a debounce FSM with states LO, PEND_HI, HI and PEND_LO; the sensor output is 1 in HI and PEND_LO and 0 otherwise.
REQ-012 LO SHALL move to PEND_HI when sync2=1, with deb_cnt set to 1; PEND_HI SHALL increment deb_cnt while sync2=1 and SHALL enter HI when deb_cnt reaches DEB_CYCLES.
REQ-013 PEND_HI SHALL return to LO with deb_cnt=0 on any cycle where sync2=0 (glitch rejected).
REQ-014 The transitions HI->PEND_LO->LO SHALL be symmetric to REQ-012 and REQ-013 with sync2 inverted.
REQ-015 Latency SHALL be exactly DEB_CYCLES+2 rising edges, counted from the first edge that samples the new raw level, until the sensor output changes.
REQ-016 A raw pulse stable for fewer than DEB_CYCLES cycles (in the sync2 domain) SHALL never appear at the output.
REQ-017 deb_cnt SHALL be $clog2(DEB_CYCLES+1) bits wide and SHALL never exceed DEB_CYCLES.
REQ-018 Each channel SHALL keep stuck_cnt, which counts consecutive cycles with the sensor output at 1, saturates at STUCK_CYCLES, and clears to 0 on any cycle the output is 0.
REQ-019 The fault bit SHALL set on the edge where stuck_cnt reaches STUCK_CYCLES and SHALL be sticky.
REQ-020 fault_clr SHALL clear all fault bits and all stuck_cnt values on the next edge; if a channel is still asserted, it SHALL re-flag after another STUCK_CYCLES cycles.
REQ-021 If fault_clr coincides with a set condition on the same edge, clear SHALL win.
REQ-022 A fault SHALL NOT alter the sensor output (reporting only).
REQ-023 Channels SHALL be fully independent; simultaneous edges on any combination of channels SHALL be handled in parallel with identical latency.

Reset
REQ-024 While reset=0 at a rising edge, sync flops, all sensor outputs, fault, fault_any, deb_cnt and stuck_cnt SHALL clear to 0, and every FSM SHALL go to LO.
REQ-025 Reset asserted mid-debounce (PEND_HI or PEND_LO) SHALL abandon the pending change.
REQ-026 After reset release, a raw input already high SHALL produce an output after the normal DEB_CYCLES+2 edges.

Structure
REQ-027 light_package SHALL add the constant SENSOR_CNT=5 and an enum deb_state_t {LO, PEND_HI, HI, PEND_LO}.
REQ-028 The per-channel logic (synchronizer, FSM, stuck counter) SHALL live in sub-module sensor_channel, instantiated SENSOR_CNT times by sensor_conditioner.
REQ-029 fault_any SHALL be combinational from the fault flops.

Verification (DEB_CYCLES=3, STUCK_CYCLES=64)
REQ-030 Raw e_left 0->1 held: e_left_sensor SHALL rise exactly 5 edges after the first sampling edge, and all other outputs SHALL stay 0.
REQ-031 A ns_raw high pulse of 2 cycles SHALL leave ns_sensor at 0, with the FSM back in LO.
REQ-032 All five raw inputs rising on the same cycle SHALL cause all five outputs to rise on the same edge; on a later simultaneous fall, all SHALL fall together 5 edges later.
REQ-033 w_str_raw held high for 80 cycles SHALL set fault[1] exactly 64 edges after w_str_sensor rises, and fault_any SHALL be 1.
REQ-034 Issuing fault_clr while w_str is still high SHALL clear fault[1] on the next edge, and it SHALL re-set 64 edges later.
REQ-035 Asserting reset during PEND_HI on e_str SHALL keep e_str_sensor at 0, and after release it SHALL rise 5 edges later if raw is still high.
